mem_sequencer: RTL
==================

MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 SHALL have parameter LATENCY, default 2, cycles from a ram_ren cycle to valid ram_rdata (legal 1..7).
REQ-002 SHALL have parameter ADDR_W, default 12, RAM word-address width.
REQ-003 SHALL have one clock and an asynchronous active-low reset; the ports are listed below.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 nRst  in  1  asynchronous active-low reset.
REQ-006 start  in  1  run enable; 0 = sequencer idles after the current instruction.
REQ-007 pc  in  32  fetch byte address.
REQ-008 dm_read, dm_write  in  1 each  load/store request for the instruction held in instr_out; never both 1.
REQ-009 dm_size  in  2  0 byte, 1 half, 2 word.
REQ-010 dm_addr  in  32  data byte address.
REQ-011 dm_wdata  in  32  store data, right-aligned.
REQ-012 ram_addr  out  ADDR_W  RAM address, equal to byte address bits [ADDR_W-1:0].
REQ-013 ram_ren, ram_wen  out  1 each  RAM read/write strobe.
REQ-014 ram_be  out  4  write byte lanes.
REQ-015 ram_wdata  out  32  lane-replicated store data.
REQ-016 ram_rdata  in  32  RAM read data.
REQ-017 instr_out  out  32  captured instruction.
REQ-018 data_out  out  32  captured raw load word.
REQ-019 pc_enable  out  1  one-cycle pulse: instruction retired, PC may advance.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 misalign_err  out  1  one-cycle pulse on a misaligned access.

Function
REQ-022 SHALL implement states IDLE, F_REQ, F_WAIT, EXEC, D_REQ, D_WAIT.
REQ-023 IDLE SHALL go to F_REQ when start=1 and SHALL otherwise stay in IDLE.
REQ-024 F_REQ SHALL drive ram_ren=1 and ram_addr=pc, SHALL load cnt=LATENCY-1, and SHALL go to F_WAIT.
REQ-025 F_WAIT SHALL decrement cnt each cycle; at cnt==0 it SHALL capture ram_rdata into instr_out and go to EXEC.
REQ-026 EXEC SHALL last one cycle, evaluate dm_read, dm_write, dm_size and dm_addr, and proceed as follows:
- valid access: go to D_REQ;
- no access: pulse pc_enable, then go to F_REQ if start=1, else IDLE.
REQ-027 A store in D_REQ SHALL drive ram_wen=1 with ram_be and ram_wdata per REQ-030, pulse pc_enable, and exit as in REQ-026.
REQ-028 A load in D_REQ SHALL drive ram_ren=1 and load cnt=LATENCY-1; D_WAIT SHALL count as F_WAIT does; at cnt==0 it SHALL capture data_out, pulse pc_enable, and exit as in REQ-026.
REQ-029 Cycles per instruction SHALL be:
- non-memory instruction: LATENCY+2;
- store: LATENCY+3;
- load: 2*LATENCY+3.
REQ-030 ram_be SHALL be as follows:
- byte: 4'b0001<<dm_addr[1:0], with data byte replicated on all lanes;
- half: dm_addr[1] ? 4'b1100 : 4'b0011, with halfword replicated on both halves;
- word: 4'b1111.
REQ-031 ram_ren, ram_wen and ram_be SHALL be 0 in every state and cycle not named above.
REQ-032 When start falls mid-instruction, the sequencer SHALL complete the instruction, including its pc_enable pulse, before entering IDLE.
REQ-033 instr_out and data_out SHALL hold their values until the next capture.

Reset
REQ-034 On nRst=0 the sequencer SHALL immediately enter IDLE, clear cnt, and drive every output to 0.
REQ-035 A reset during F_WAIT or D_WAIT SHALL abandon the access with no capture and no pc_enable pulse.

Configuration
REQ-036 With MEM_SEQUENCER_ALIGN_CHECK_EN defined, a misaligned access SHALL make EXEC pulse misalign_err, skip D_REQ, and pulse pc_enable. Misaligned means word with dm_addr[1:0]!=0, or half with dm_addr[0]!=0.
REQ-037 Without MEM_SEQUENCER_ALIGN_CHECK_EN, misalign_err SHALL be tied to 0 and the offending low address bits SHALL be treated as zero.

Structure
REQ-038 Package mem_seq_pkg SHALL hold the state enum, the dm_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), and the LATENCY default.
REQ-039 Byte-lane and replication logic SHALL be sub-module mem_lane_gen.

Verification
REQ-040 LATENCY=2, start=1, no dm requests -> pc_enable pulses every 4 cycles; instr_out equals the RAM word at each pc.
REQ-041 Store word 0xDEADBEEF at 0x010 -> exactly one ram_wen cycle with ram_addr=0x010 and ram_be=1111; pc_enable pulses 5 cycles after F_REQ.
REQ-042 Store byte 0xA5 at 0x013 -> ram_be=1000 and ram_wdata=0xA5A5A5A5.
REQ-043 Load at 0x020 with RAM word 0x12345678 -> data_out=0x12345678; pc_enable pulses 7 cycles after F_REQ.
REQ-044 Word load at 0x022 with the macro defined -> misalign_err pulse, no ram_ren in D_REQ, pc_enable in the same cycle.
REQ-045 nRst low in F_WAIT, then high with start=1 -> all outputs 0 during reset, no pc_enable pulse, new fetch begins at F_REQ.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the mem_sequencer instruction/data sequencer.
package mem_seq_pkg;

    localparam int LATENCY_DEFAULT = 2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        F_REQ,
        F_WAIT,
        EXEC,
        D_REQ,
        D_WAIT
    } seq_state_t;

endpackage

// File: rtl/mem_lane_gen.sv
// Store byte-lane enables and lane-replicated write data for a given access size and offset.
module mem_lane_gen
    import mem_seq_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep
);

    // Unknown size encodings fall through to a full-word access.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = 32'h0;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = offset[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_sequencer.sv
// Fetch/execute/data-access sequencer for a fixed-latency single-port RAM.
// Optional alignment trapping is enabled with `define MEM_SEQUENCER_ALIGN_CHECK_EN.
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEFAULT,
    parameter int ADDR_W  = 12
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              start,
    input  logic [31:0]       pc,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [1:0]        dm_size,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       instr_out,
    output logic [31:0]       data_out,
    output logic              pc_enable,
    output logic              busy,
    output logic              misalign_err
);

    seq_state_t  state;
    seq_state_t  next_state;
    seq_state_t  after_instr;
    logic [2:0]  cnt;
    logic [1:0]  eff_lo;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        access;
    logic        unused_bits;

    assign unused_bits = ^{pc[31:ADDR_W], dm_addr[31:ADDR_W]};

    assign access      = dm_read | dm_write;
    assign after_instr = start ? F_REQ : IDLE;
    assign busy        = (state != IDLE);

    // Low address bits that the access size cannot use are forced to zero.
    always_comb begin
        eff_lo = 2'b00;
        case (dm_size)
            SZ_BYTE: eff_lo = dm_addr[1:0];
            SZ_HALF: eff_lo = {dm_addr[1], 1'b0};
            default: eff_lo = 2'b00;
        endcase
    end

`ifdef MEM_SEQUENCER_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = (dm_size == SZ_HALF) ? dm_addr[0]
                      : (dm_size == SZ_BYTE) ? 1'b0
                      : (dm_addr[1:0] != 2'b00);
`endif

    mem_lane_gen u_lane_gen (
        .size      (dm_size),
        .offset    (eff_lo),
        .wdata     (dm_wdata),
        .be        (lane_be),
        .wdata_rep (lane_wdata)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            instr_out <= 32'h0;
            data_out  <= 32'h0;
        end else begin
            case (state)
                F_REQ, D_REQ:   cnt <= 3'(LATENCY - 1);
                F_WAIT, D_WAIT: if (cnt != 3'd0) cnt <= cnt - 3'd1;
                default:        ;
            endcase
            if (state == F_WAIT && cnt == 3'd0) instr_out <= ram_rdata;
            if (state == D_WAIT && cnt == 3'd0) data_out  <= ram_rdata;
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        ram_addr     = '0;
        ram_ren      = 1'b0;
        ram_wen      = 1'b0;
        ram_be       = 4'b0000;
        ram_wdata    = 32'h0;
        pc_enable    = 1'b0;
        misalign_err = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = F_REQ;
            end
            F_REQ: begin
                ram_ren    = 1'b1;
                ram_addr   = pc[ADDR_W-1:0];
                next_state = F_WAIT;
            end
            F_WAIT: begin
                if (cnt == 3'd0) next_state = EXEC;
            end
            EXEC: begin
                if (!access) begin
                    pc_enable  = 1'b1;
                    next_state = after_instr;
                end else begin
`ifdef MEM_SEQUENCER_ALIGN_CHECK_EN
                    if (misaligned) begin
                        misalign_err = 1'b1;
                        pc_enable    = 1'b1;
                        next_state   = after_instr;
                    end else begin
                        next_state = D_REQ;
                    end
`else
                    next_state = D_REQ;
`endif
                end
            end
            D_REQ: begin
                ram_addr = {dm_addr[ADDR_W-1:2], eff_lo};
                if (dm_write) begin
                    ram_wen    = 1'b1;
                    ram_be     = lane_be;
                    ram_wdata  = lane_wdata;
                    pc_enable  = 1'b1;
                    next_state = after_instr;
                end else begin
                    ram_ren    = 1'b1;
                    next_state = D_WAIT;
                end
            end
            D_WAIT: begin
                if (cnt == 3'd0) begin
                    pc_enable  = 1'b1;
                    next_state = after_instr;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
